// File: rtl/uart_char_display.sv
// UART character line buffer with echo handshake and tick-enabled digit scan.
// Entry 0 is the rightmost digit; scan_char feeds the external ASCII-to-segment decoder.

module ucd_cell (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= 8'h00;
    else if (ld) q <= d;
endmodule

module uart_char_display #(
  parameter int NUM_DIGITS = 4,
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int SCAN_RATE  = 1000,
  parameter int ECHO_EN    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic                            echo_overflow,
  output logic [$clog2(NUM_DIGITS+1)-1:0] char_count,
  output logic [7:0]                      scan_char,
  output logic [NUM_DIGITS-1:0]           an,
  output logic                            dp
);
  localparam int TICK_DIV = CLOCK_FREQ / SCAN_RATE;
  localparam int IDX_W    = $clog2(NUM_DIGITS);
  localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W    = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_DIGITS);
  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  // ---------------- byte classification ----------------
  logic is_pr, is_bs, is_cl, accept, buf_upd;
  assign is_pr   = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
  assign is_bs   = (rx_data == 8'h08) || (rx_data == 8'h7F);
  assign is_cl   = (rx_data == 8'h0D) || (rx_data == 8'h1B);
  assign accept  = rx_valid && (is_pr || is_bs || is_cl);
  // Backspace on an empty line is accepted (echoed) but leaves the buffer alone.
  assign buf_upd = rx_valid && (is_pr || is_cl || (is_bs && char_count != '0));

  // ---------------- line buffer ----------------
  logic [NUM_DIGITS-1:0][7:0] buf_q, buf_d;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_cell
    logic [7:0] shl, shr;
    if (i == 0) begin : g_shl_rx
      assign shl = rx_data;
    end else begin : g_shl_buf
      assign shl = buf_q[i-1];
    end
    if (i == NUM_DIGITS - 1) begin : g_shr_zero
      assign shr = 8'h00;
    end else begin : g_shr_buf
      assign shr = buf_q[i+1];
    end
    assign buf_d[i] = is_cl ? 8'h00 : (is_pr ? shl : shr);

    ucd_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (buf_upd),
      .d     (buf_d[i]),
      .q     (buf_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                 char_count <= '0;
    else if (rx_valid && is_cl)                 char_count <= '0;
    else if (rx_valid && is_pr && char_count != CNT_MAX)
                                                char_count <= char_count + 1'b1;
    else if (rx_valid && is_bs && char_count != '0)
                                                char_count <= char_count - 1'b1;

  // ---------------- echo ----------------
  typedef enum logic {TX_IDLE, TX_BUSY} tx_st_t;
  tx_st_t     tx_st, tx_st_d;
  logic [7:0] tx_data_d;
  logic       ovf_d, echo_acc;

  assign echo_acc = accept && (ECHO_EN != 0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_st         <= TX_IDLE;
      tx_data       <= 8'h00;
      echo_overflow <= 1'b0;
    end else begin
      tx_st         <= tx_st_d;
      tx_data       <= tx_data_d;
      echo_overflow <= ovf_d;
    end

  always_comb begin
    tx_st_d   = tx_st;
    tx_data_d = tx_data;
    ovf_d     = echo_overflow;
    case (tx_st)
      TX_IDLE:
        if (echo_acc) begin
          tx_st_d   = TX_BUSY;
          tx_data_d = rx_data;
        end
      TX_BUSY:
        if (tx_ready) begin
          if (echo_acc) tx_data_d = rx_data;
          else          tx_st_d   = TX_IDLE;
        end else if (echo_acc) begin
          ovf_d = 1'b1;  // transmitter still busy: drop the byte, keep tx_data stable
        end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  assign tx_valid = (tx_st == TX_BUSY);

  // ---------------- digit scan ----------------
  logic [PS_W-1:0]  ps_q;
  logic [IDX_W-1:0] idx_q, idx_nx;
  logic             wrap;

  assign wrap   = (ps_q == PS_MAX);
  assign idx_nx = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ps_q  <= '0;
      idx_q <= '0;
      an    <= ~NUM_DIGITS'(1);
    end else begin
      ps_q <= wrap ? '0 : ps_q + 1'b1;
      if (wrap) begin
        idx_q <= idx_nx;
        an    <= ~(NUM_DIGITS'(1) << idx_nx);
      end
    end

  assign scan_char = buf_q[idx_q];
  assign dp        = 1'b1;

endmodule
